writeback_unit: RTL and testbench

Register-file write-side front end for the RV32 core. Collects results from the single-cycle ALU path and the long-latency load/multi-cycle path, buffers long-latency results in a small FIFO, and arbitrates them onto the register file's single write port (`wen`/`wraddr`/`wrdata`). Also keeps a 32-bit pending scoreboard so decode can stall on operands whose long-latency producer has not yet written back.

---
 rtl/writeback_unit_if.sv | 30 +++
 rtl/writeback_unit.sv | 69 ++++++
 tb/tb_writeback_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/writeback_unit_if.sv
// writeback_unit_if: writeback bundle (ALU, LSU, issue, decode query, regfile write); slave = writeback_unit, master = core side
interface writeback_unit_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  query_rs1;
  logic [4:0]  query_rs2;
  logic        busy1;
  logic        busy2;
  logic        alu_stall;
  logic        wen;
  logic [4:0]  wraddr;
  logic [31:0] wrdata;
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_valid, issue_rd, query_rs1, query_rs2,
    input  lsu_ready, busy1, busy2, alu_stall, wen, wraddr, wrdata
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_valid, issue_rd, query_rs1, query_rs2,
    output lsu_ready, busy1, busy2, alu_stall, wen, wraddr, wrdata
  );
endinterface

// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates ALU results and FIFO-buffered long-path results onto one regfile write port, with pending scoreboard; clk/rst (async high) plus writeback_unit_if.slave bus; WB_STARVE_GUARD_EN enables the FIFO starvation guard
module writeback_unit #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic clk,
  input logic rst,
  writeback_unit_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [36:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [31:0]   pending, pending_next;
  logic          empty, full, push, pop, alu_win, stall;
  assign empty         = count == '0;
  assign full          = count == (AW+1)'(FIFO_DEPTH);
  assign bus.lsu_ready = !full;
  assign push          = bus.lsu_valid && !full && bus.lsu_rd != '0;
  // a stalled or x0 ALU result never wins, so the FIFO head drains that cycle
  assign alu_win       = bus.alu_valid && bus.alu_rd != '0 && !stall;
  assign pop           = !empty && !alu_win;
  assign bus.busy1     = pending[bus.query_rs1];
  assign bus.busy2     = pending[bus.query_rs2];
  assign bus.alu_stall = stall;
  // issue is applied after the pop clear so a same-index set wins
  always_comb begin
    pending_next = pending;
    if (pop) pending_next[mem[rptr][36:32]] = 1'b0;
    if (bus.issue_valid) pending_next[bus.issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {bus.lsu_rd, bus.lsu_data};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.wen    <= 1'b0;
      bus.wraddr <= '0;
      bus.wrdata <= '0;
      pending    <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
    end else begin
      bus.wen <= alu_win || pop;
      if (alu_win) {bus.wraddr, bus.wrdata} <= {bus.alu_rd, bus.alu_data};
      else if (pop) {bus.wraddr, bus.wrdata} <= mem[rptr];
      pending <= pending_next;
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
`ifdef WB_STARVE_GUARD_EN
  logic [7:0] starve, starve_next;
  logic       stall_q;
  assign starve_next = (empty || pop) ? '0 : alu_win ? starve + 8'd1 : starve;
  assign stall       = stall_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      starve  <= '0;
      stall_q <= 1'b0;
    end else begin
      starve  <= starve_next;
      stall_q <= starve_next == 8'(STARVE_LIMIT);
    end
`else
  assign stall = 1'b0;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed and randomized checks of writeback_unit against a queue-based reference model
module tb_writeback_unit;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int nvec = 0;
  int nerr = 0;
  writeback_unit_if bus();
  writeback_unit #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [36:0] q[$];
  logic [31:0] pend;
  logic        m_wen, m_stall;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          losses;
  task automatic model_reset();
    q.delete();
    pend = '0; m_wen = 0; m_addr = '0; m_data = '0; m_stall = 0; losses = 0;
  endtask
  task automatic idle();
    bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.issue_valid = 0; bus.issue_rd = '0;
  endtask
  task automatic tick();
    bit aw, pp, hs, was_empty;
    logic [36:0] h;
    was_empty = q.size() == 0;
    aw = bus.alu_valid && bus.alu_rd != 0 && !m_stall;
    pp = !aw && !was_empty;
    hs = bus.lsu_valid && q.size() < DEPTH && bus.lsu_rd != 0;
    if (aw) begin
      m_wen = 1; m_addr = bus.alu_rd; m_data = bus.alu_data;
    end else if (pp) begin
      h = q.pop_front();
      m_wen = 1; {m_addr, m_data} = h;
      pend[h[36:32]] = 1'b0;
    end else m_wen = 0;
    if (bus.issue_valid && bus.issue_rd != 0) pend[bus.issue_rd] = 1'b1;
    if (hs) q.push_back({bus.lsu_rd, bus.lsu_data});
    losses = (was_empty || pp) ? 0 : losses + 1;
    m_stall = GUARD && losses == LIMIT;
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    idle(); bus.query_rs1 = 5'd7; bus.query_rs2 = 5'd9;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (bus.wen !== 1'b0) begin nerr++; $display("FAIL reset_wen: got %b want 0", bus.wen); end
    nvec++; if (bus.wraddr !== 5'd0 || bus.wrdata !== 32'd0) begin nerr++; $display("FAIL reset_wr: got %h/%h want 0/0", bus.wraddr, bus.wrdata); end
    nvec++; if (bus.lsu_ready !== 1'b1 || bus.alu_stall !== 1'b0) begin nerr++; $display("FAIL reset_ready_stall: got %b%b want 10", bus.lsu_ready, bus.alu_stall); end
    nvec++; if (bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b%b want 00", bus.busy1, bus.busy2); end
    rst = 0;
  endtask
  task automatic test_alu_write();
    idle();
    bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    tick();
    bus.alu_valid = 0;
    nvec++; if ({bus.wen, bus.wraddr, bus.wrdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin nerr++; $display("FAIL alu_write: got %b/%0d/%h want 1/5/deadbeef", bus.wen, bus.wraddr, bus.wrdata); end
    tick();
    nvec++; if ({bus.wen, bus.wraddr, bus.wrdata} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin nerr++; $display("FAIL alu_hold: got %b/%0d/%h want 0/5/deadbeef", bus.wen, bus.wraddr, bus.wrdata); end
  endtask
  task automatic test_scoreboard();
    idle();
    bus.issue_valid = 1; bus.issue_rd = 5'd7; bus.query_rs1 = 5'd7;
    tick();
    bus.issue_valid = 0;
    nvec++; if (bus.busy1 !== 1'b1) begin nerr++; $display("FAIL sb_set: got %b want 1", bus.busy1); end
    repeat (4) tick();
    bus.lsu_valid = 1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h1234;
    tick();
    bus.lsu_valid = 0;
    nvec++; if (bus.wen !== 1'b0 || bus.busy1 !== 1'b1) begin nerr++; $display("FAIL sb_head: got wen=%b busy=%b want 0 1", bus.wen, bus.busy1); end
    tick();
    nvec++; if ({bus.wen, bus.wraddr, bus.wrdata} !== {1'b1, 5'd7, 32'h1234}) begin nerr++; $display("FAIL sb_write: got %b/%0d/%h want 1/7/1234", bus.wen, bus.wraddr, bus.wrdata); end
    nvec++; if (bus.busy1 !== 1'b0) begin nerr++; $display("FAIL sb_clear: got %b want 0", bus.busy1); end
  endtask
  task automatic test_x0();
    idle();
    bus.issue_valid = 1; bus.issue_rd = 5'd3; bus.query_rs2 = 5'd3;
    bus.alu_valid = 1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
    bus.lsu_valid = 1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'h33;
    tick();
    bus.issue_valid = 0; bus.lsu_valid = 0; bus.alu_rd = 5'd0; bus.alu_data = 32'hBAD;
    tick();
    nvec++; if ({bus.wen, bus.wraddr, bus.wrdata} !== {1'b1, 5'd3, 32'h33}) begin nerr++; $display("FAIL x0_alu: got %b/%0d/%h want 1/3/33", bus.wen, bus.wraddr, bus.wrdata); end
    nvec++; if (bus.busy2 !== 1'b0) begin nerr++; $display("FAIL x0_busy: got %b want 0", bus.busy2); end
    bus.alu_valid = 0; bus.lsu_valid = 1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'h77;
    nvec++; if (bus.lsu_ready !== 1'b1) begin nerr++; $display("FAIL x0_lsu_ready: got %b want 1", bus.lsu_ready); end
    tick();
    bus.lsu_valid = 0;
    for (int i = 0; i < 3; i++) begin
      nvec++; if (bus.wen !== 1'b0) begin nerr++; $display("FAIL x0_lsu_nowrite: got %b want 0", bus.wen); end
      tick();
    end
  endtask
  task automatic test_backpressure();
    idle();
    bus.alu_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.alu_rd = 5'(1 + i); bus.alu_data = $urandom;
      bus.lsu_valid = 1; bus.lsu_rd = 5'(10 + i); bus.lsu_data = 32'(100 + i);
      tick();
    end
    bus.lsu_valid = 0;
    nvec++; if (bus.lsu_ready !== 1'b0) begin nerr++; $display("FAIL bp_full: got %b want 0", bus.lsu_ready); end
    bus.alu_valid = 0;
    tick();
    nvec++; if ({bus.wen, bus.wraddr, bus.wrdata, bus.lsu_ready} !== {1'b1, 5'd10, 32'd100, 1'b1}) begin nerr++; $display("FAIL bp_pop: got %b/%0d/%0d/%b want 1/10/100/1", bus.wen, bus.wraddr, bus.wrdata, bus.lsu_ready); end
    repeat (DEPTH) tick();
  endtask
  task automatic test_reset_mid();
    idle();
    bus.alu_valid = 1; bus.alu_rd = 5'd4; bus.alu_data = 32'h44;
    bus.query_rs1 = 5'd12; bus.query_rs2 = 5'd13;
    for (int i = 0; i < 2; i++) begin
      bus.issue_valid = 1; bus.issue_rd = 5'(12 + i);
      bus.lsu_valid = 1; bus.lsu_rd = 5'(12 + i); bus.lsu_data = $urandom;
      tick();
    end
    idle();
    nvec++; if (bus.busy1 !== 1'b1 || bus.busy2 !== 1'b1 || bus.wen !== 1'b1) begin nerr++; $display("FAIL rm_pre: got %b%b%b want 111", bus.busy1, bus.busy2, bus.wen); end
    #3 rst = 1;
    #1;
    nvec++; if ({bus.wen, bus.wraddr, bus.wrdata, bus.alu_stall} !== 39'd0) begin nerr++; $display("FAIL rm_out: got %b/%0d/%h/%b want 0", bus.wen, bus.wraddr, bus.wrdata, bus.alu_stall); end
    nvec++; if ({bus.lsu_ready, bus.busy1, bus.busy2} !== 3'b100) begin nerr++; $display("FAIL rm_ready_busy: got %b want 100", {bus.lsu_ready, bus.busy1, bus.busy2}); end
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    tick();
    nvec++; if (bus.wen !== 1'b0) begin nerr++; $display("FAIL rm_discard: got %b want 0", bus.wen); end
  endtask
  task automatic test_starve();
    int first;
    idle();
    bus.alu_valid = 1; bus.alu_rd = 5'd2; bus.alu_data = 32'h2;
    bus.lsu_valid = 1; bus.lsu_rd = 5'd21; bus.lsu_data = 32'h2121;
    tick();
    bus.lsu_valid = 0;
`ifdef WB_STARVE_GUARD_EN
    first = -1;
    for (int i = 1; i <= 20 && first < 0; i++) begin
      bus.alu_rd = 5'($urandom_range(1, 31)); bus.alu_data = $urandom;
      tick();
      if (bus.alu_stall === 1'b1) first = i;
    end
    nvec++; if (first != LIMIT) begin nerr++; $display("FAIL starve_when: got %0d want %0d", first, LIMIT); end
    bus.alu_rd = 5'd6; bus.alu_data = 32'h66;
    tick();
    nvec++; if ({bus.wen, bus.wraddr, bus.wrdata, bus.alu_stall} !== {1'b1, 5'd21, 32'h2121, 1'b0}) begin nerr++; $display("FAIL starve_pop: got %b/%0d/%h/%b want 1/21/2121/0", bus.wen, bus.wraddr, bus.wrdata, bus.alu_stall); end
    tick();
    nvec++; if ({bus.wen, bus.wraddr, bus.wrdata} !== {1'b1, 5'd6, 32'h66}) begin nerr++; $display("FAIL starve_resume: got %b/%0d/%h want 1/6/66", bus.wen, bus.wraddr, bus.wrdata); end
`else
    first = 0;
    for (int i = 0; i < 12; i++) begin
      bus.alu_rd = 5'($urandom_range(1, 31)); bus.alu_data = $urandom;
      tick();
      nvec++; if (bus.alu_stall !== 1'b0 || bus.wraddr !== bus.alu_rd) begin nerr++; $display("FAIL strict_prio: got stall=%b wraddr=%0d want 0/%0d", bus.alu_stall, bus.wraddr, bus.alu_rd); end
    end
    bus.alu_valid = 0;
    tick();
    nvec++; if ({bus.wen, bus.wraddr, bus.wrdata} !== {1'b1, 5'd21, 32'h2121}) begin nerr++; $display("FAIL strict_drain: got %b/%0d/%h want 1/21/2121 after %0d", bus.wen, bus.wraddr, bus.wrdata, first); end
`endif
    idle();
    repeat (2) tick();
  endtask
  task automatic test_random();
    logic [42:0] got, want;
    for (int i = 0; i < 400; i++) begin
      bus.alu_valid = $urandom_range(0, 99) < 55;
      bus.alu_rd = 5'($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 31));
      bus.alu_data = $urandom;
      bus.lsu_valid = $urandom_range(0, 99) < 60;
      bus.lsu_rd = 5'($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 31));
      bus.lsu_data = $urandom;
      bus.issue_valid = $urandom_range(0, 1);
      bus.issue_rd = 5'($urandom);
      bus.query_rs1 = 5'($urandom);
      bus.query_rs2 = 5'($urandom);
      tick();
      got  = {bus.wen, bus.wraddr, bus.wrdata, bus.lsu_ready, bus.alu_stall, bus.busy1, bus.busy2};
      want = {m_wen, m_addr, m_data, q.size() < DEPTH, m_stall, pend[bus.query_rs1], pend[bus.query_rs2]};
      nvec++; if (got !== want) begin nerr++; $display("FAIL random[%0d]: got %h want %h", i, got, want); end
    end
  endtask
  initial begin
    test_reset();
    test_alu_write();
    test_scoreboard();
    test_x0();
    test_backpressure();
    test_reset_mid();
    test_starve();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
